lsu_mem_port: RTL
=================

// Module: lsu_mem_port
// PURPOSE
//  Core-side initiator for the data-memory controller port (dm_rd_ctrl/dm_wr_ctrl/dm_addr/dm_din/dm_dout).
//  Accepts byte/half/word/double loads and stores from the MEM stage.
//  Issues only aligned 64-bit memory accesses; sub-word stores use read-modify-write.
//  Extracts and sign- or zero-extends load data, and flags misaligned and out-of-window accesses.
// PARAMETERS
//  BASE_ADDR   64'h8000_0000  first byte address of the DRAM window
//  MEM_BYTES   65536          window size in bytes (8192 x 64-bit words)
//  MEM_RD_LAT  1              cycles from read issue to valid dm_dout (0 = combinational)
// PORTS
//  clk          in   1   single clock, all state on rising edge
//  rst          in   1   synchronous, active-high reset
//  req_valid    in   1   request present
//  req_ready    out  1   high only in IDLE; transfer on req_valid&&req_ready
//  req_we       in   1   1=store, 0=load
//  req_size     in   2   0=byte 1=half 2=word 3=double
//  req_unsigned in   1   zero-extend load (ignored for stores and for double)
//  req_addr     in   64  byte address
//  req_wdata    in   64  store data, right-aligned (low bytes used)
//  resp_valid   out  1   one-cycle pulse, no backpressure
//  resp_rdata   out  64  extended load data; 0 for stores/errors
//  resp_err     out  1   misaligned or outside [BASE_ADDR, BASE_ADDR+MEM_BYTES)
//  dm_rd_ctrl   out  3   3'b111 (LD) while reading, else 3'b000
//  dm_wr_ctrl   out  3   3'b100 (SD) in write cycle, else 3'b000
//  dm_addr      out  64  {req_addr[63:3],3'b000}, held stable through RD/WR
//  dm_din       out  64  merged write word (valid when dm_wr_ctrl!=0)
//  dm_dout      in   64  read word from memory
// BEHAVIOUR
//  Reset: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, dm_*ctrl=0, dm_addr=0, dm_din=0.
//  All outputs are registered. Request fields are latched at acceptance.
//  Accepting a request is cycle 0.
//  States:
//   IDLE -> ERR  if misaligned (addr[size-1:0]!=0) or out of window; no memory access
//   IDLE -> WR   if store and size=3
//   IDLE -> RD   otherwise
//   RD   : drive LD for MEM_RD_LAT+1 cycles (down-counter); sample dm_dout on the last edge
//          -> RESP if load, -> WR if store
//   WR   : one cycle, dm_wr_ctrl=SD
//          dm_din = sampled word with bytes [off, off+2^size) replaced by low req_wdata bytes
//          (off = addr[2:0]); -> RESP
//   RESP/ERR : resp_valid=1 for one cycle -> IDLE
//  Latency (MEM_RD_LAT=L):
//   load:     resp_valid in cycle L+2
//   sub-store: write in cycle L+2, resp_valid in cycle L+3
//   SD:       write in cycle 1, resp_valid in cycle 2
//   error:    resp_valid in cycle 1
//  Load extract: field = word >> (8*off), truncated to 2^size bytes.
//   Sign-extend unless req_unsigned.
//   Size 3 returns the word as-is.
//  Boundary: addr = BASE_ADDR+MEM_BYTES-1 with byte size is legal; +MEM_BYTES errors.
//   The window check uses the full 64-bit compare, with no wrap.
//  req_valid outside IDLE is ignored (ready=0); the bench must hold the request.
//  Reset mid-operation: next cycle IDLE, all ctrl outputs 0, pending request dropped, no response.
//   A write presented in the reset cycle itself completes (memory samples the same edge).
//  Only one request is ever outstanding; back-to-back acceptance is possible the cycle after RESP/ERR.
// TESTING
//  SD 0x1122334455667788 @0x80000010 ->
//   dm_wr_ctrl=4 cycle 1, dm_addr=0x80000010, resp cycle 2.
//   Then LD same addr -> resp_rdata=0x1122334455667788, cycle 3 (L=1).
//  SB 0xAB @0x80000013 over that word ->
//   RD cycles 1-2, WR cycle 3 with dm_din=0x11223344AB667788, resp cycle 4.
//  LB @0x80000013 -> 0xFFFF_FFFF_FFFF_FFAB; LBU -> 0xAB.
//   LW @0x80000014 -> 0x0000_0000_1122_3344.
//  LH @0x80000011 -> resp_err=1 in cycle 1, dm_rd_ctrl/dm_wr_ctrl never nonzero.
//   LD @0x7FFFFFF8 -> resp_err=1.
//  Assert rst in RD cycle 1 of a SB ->
//   no WR cycle, no resp_valid, req_ready=1 next cycle, memory word unchanged.
//  Repeat load/store checks with MEM_RD_LAT=0 and 3 ->
//   load resp cycles 2 and 5; dm_addr/dm_rd_ctrl stable across all RD cycles.

Source files
------------

// File: rtl/lsu_mem_port.sv
// Core-side LSU initiator: aligned 64-bit data-memory accesses, read-modify-write for sub-word stores.
// Latency: error 1, SD 2, load L+2, sub-word store L+3 cycles; single outstanding request, responses are never stalled.
module lsu_mem_port #(
    parameter logic [63:0] BASE_ADDR  = 64'h8000_0000,
    parameter int          MEM_BYTES  = 65536,
    parameter int          MEM_RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic [2:0]  dm_rd_ctrl,
    output logic [2:0]  dm_wr_ctrl,
    output logic [63:0] dm_addr,
    output logic [63:0] dm_din,
    input  logic [63:0] dm_dout
);
    typedef enum logic [2:0] {IDLE, RD, WR, RESP, ERR} state_t;

    localparam logic [63:0] LIMIT = BASE_ADDR + 64'(MEM_BYTES);
    localparam logic [7:0]  LAT   = 8'(MEM_RD_LAT);

    state_t      state, state_n;
    logic [7:0]  cnt;
    logic        we_q, uns_q;
    logic [1:0]  size_q;
    logic [2:0]  off_q;
    logic [63:0] wdata_q;
    logic        accept, misaligned, in_window, rd_done;
    logic [63:0] field, load_data, merged, wshift;
    logic [7:0]  be_base, be;

    assign accept    = req_valid && req_ready;
    assign in_window = (req_addr >= BASE_ADDR) && (req_addr < LIMIT);
    assign rd_done   = (state == RD) && (cnt == 8'd0);

    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'd1:    misaligned = req_addr[0];
            2'd2:    misaligned = |req_addr[1:0];
            2'd3:    misaligned = |req_addr[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (misaligned || !in_window)     state_n = ERR;
                    else if (req_we && req_size == 2'd3) state_n = WR;
                    else                              state_n = RD;
                end
            end
            RD:      if (rd_done) state_n = we_q ? WR : RESP;
            WR:      state_n = RESP;
            RESP:    state_n = IDLE;
            ERR:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Load extraction: shift the addressed field down, then extend to 64 bits.
    always_comb begin
        field     = dm_dout >> {off_q, 3'b000};
        load_data = dm_dout;
        case (size_q)
            2'd0:    load_data = uns_q ? {56'd0, field[7:0]}  : {{56{field[7]}},  field[7:0]};
            2'd1:    load_data = uns_q ? {48'd0, field[15:0]} : {{48{field[15]}}, field[15:0]};
            2'd2:    load_data = uns_q ? {32'd0, field[31:0]} : {{32{field[31]}}, field[31:0]};
            default: load_data = dm_dout;
        endcase
    end

    // Store merge: replace the addressed bytes of the read word with the low store bytes.
    always_comb begin
        case (size_q)
            2'd0:    be_base = 8'h01;
            2'd1:    be_base = 8'h03;
            2'd2:    be_base = 8'h0F;
            default: be_base = 8'hFF;
        endcase
        be     = be_base << off_q;
        wshift = wdata_q << {off_q, 3'b000};
        merged = dm_dout;
        for (int i = 0; i < 8; i++) begin
            if (be[i]) merged[i*8 +: 8] = wshift[i*8 +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            dm_rd_ctrl <= 3'b000;
            dm_wr_ctrl <= 3'b000;
            dm_addr    <= '0;
            dm_din     <= '0;
            cnt        <= '0;
            we_q       <= 1'b0;
            uns_q      <= 1'b0;
            size_q     <= 2'd0;
            off_q      <= 3'd0;
            wdata_q    <= '0;
        end else begin
            state      <= state_n;
            req_ready  <= (state_n == IDLE);
            resp_valid <= (state_n == RESP) || (state_n == ERR);
            resp_err   <= (state_n == ERR);
            dm_rd_ctrl <= (state_n == RD) ? 3'b111 : 3'b000;
            dm_wr_ctrl <= (state_n == WR) ? 3'b100 : 3'b000;
            if (accept) begin
                we_q       <= req_we;
                uns_q      <= req_unsigned;
                size_q     <= req_size;
                off_q      <= req_addr[2:0];
                wdata_q    <= req_wdata;
                dm_addr    <= {req_addr[63:3], 3'b000};
                dm_din     <= req_wdata;
                resp_rdata <= '0;
                cnt        <= LAT;
            end
            if (state == RD && cnt != 8'd0) cnt <= cnt - 8'd1;
            // The last RD edge is where dm_dout is valid; capture it straight into the output registers.
            if (rd_done) begin
                if (we_q) dm_din     <= merged;
                else      resp_rdata <= load_data;
            end
        end
    end
endmodule
